// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory, write-back.
// Strobes are decoded from the current state and the fields latched in DECODE.
module riscv_multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [4:0]       rd,
    input  logic             branch_taken,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic [1:0]       alu_src_a,
    output logic             alu_src_b,
    output logic [3:0]       alu_op,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret
);
    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [3:0] {C_R, C_IALU, C_LOAD, C_STORE, C_BR,
                              C_JAL, C_JALR, C_LUI, C_AUIPC} cls_t;

    state_t            state_q, state_d;
    cls_t              cls_q, cls_d;
    logic [2:0]        f3_q, f3_d;
    logic              f7b5_q, f7b5_d;
    logic [4:0]        rd_q, rd_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              retire;

    logic              unused_f7;
    assign unused_f7 = ^{funct7[6], funct7[4:0]};

    function automatic logic [3:0] alu_op_of(input cls_t c, input logic [2:0] f3, input logic b5);
        case (c)
            C_R:     return {b5, f3};
            C_IALU:  return {b5 & (f3 == 3'b101), f3};
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [1:0] src_a_of(input cls_t c);
        case (c)
            C_AUIPC: return 2'd1;
            C_LUI:   return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    logic [3:0] alu_op_l;
    logic [1:0] src_a_l;
    logic       src_b_l;
    assign alu_op_l = alu_op_of(cls_q, f3_q, f7b5_q);
    assign src_a_l  = src_a_of(cls_q);
    assign src_b_l  = !(cls_q == C_R || cls_q == C_BR);

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        f3_d      = f3_q;
        f7b5_d    = f7b5_q;
        rd_d      = rd_q;
        cnt_d     = '0;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        retire    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = S_DECODE;
                end else if (cnt_q == TO_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_DECODE: begin
                f3_d    = funct3;
                f7b5_d  = funct7[5];
                rd_d    = rd;
                state_d = S_EXEC;
                case (opcode)
                    7'b0110011: cls_d = C_R;
                    7'b0010011: cls_d = C_IALU;
                    7'b0000011: cls_d = C_LOAD;
                    7'b0100011: cls_d = C_STORE;
                    7'b1100011: cls_d = C_BR;
                    7'b1101111: cls_d = C_JAL;
                    7'b1100111: cls_d = C_JALR;
                    7'b0110111: cls_d = C_LUI;
                    7'b0010111: cls_d = C_AUIPC;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_EXEC: begin
                if (cls_q == C_LOAD || cls_q == C_STORE) begin
                    state_d = S_MEM;
                end else if (cls_q == C_BR) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (cls_q == C_STORE) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (cnt_q == TO_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
        instret_d = instret_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cls_q     <= C_R;
            f3_q      <= '0;
            f7b5_q    <= 1'b0;
            rd_q      <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            f3_q      <= f3_d;
            f7b5_q    <= f7b5_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            instret_q <= instret_d;
        end
    end

    // Gating with rst_n drops any live request the moment reset asserts.
    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'd0;
        reg_we    = 1'b0;
        wb_sel    = 2'd0;
        alu_src_a = 2'd0;
        alu_src_b = 1'b0;
        alu_op    = 4'd0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                S_EXEC: begin
                    alu_src_a = src_a_l;
                    alu_src_b = src_b_l;
                    alu_op    = alu_op_l;
                    if (cls_q == C_BR) begin
                        pc_we  = 1'b1;
                        pc_sel = branch_taken ? 2'd1 : 2'd0;
                    end
                end
                S_MEM: begin
                    alu_src_a = src_a_l;
                    alu_src_b = src_b_l;
                    alu_op    = alu_op_l;
                    dmem_req  = 1'b1;
                    dmem_we   = (cls_q == C_STORE);
                    pc_we     = (cls_q == C_STORE) && dmem_ready;
                end
                S_WB: begin
                    alu_src_a = src_a_l;
                    alu_src_b = src_b_l;
                    alu_op    = alu_op_l;
                    reg_we    = (rd_q != 5'd0);
                    pc_we     = 1'b1;
                    if (cls_q == C_LOAD) begin
                        wb_sel = 2'd1;
                    end else if (cls_q == C_JAL || cls_q == C_JALR) begin
                        wb_sel = 2'd2;
                    end
                    if (cls_q == C_JAL) begin
                        pc_sel = 2'd1;
                    end else if (cls_q == C_JALR) begin
                        pc_sel = 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign instret = instret_q;

endmodule
